dancepad_event_tx: RTL and testbench

DANCEPAD_EVENT_TX -- requirements
Module: dancepad_event_tx

---
 rtl/dancepad_event_tx_pkg.sv | 24 ++
 rtl/dancepad_event_tx_if.sv | 11 +
 rtl/dancepad_event_tx_uart_transmitter.sv | 96 +++++++++
 rtl/dancepad_event_tx.sv | 79 +++++++
 tb/tb_dancepad_event_tx.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/dancepad_event_tx_pkg.sv
// Shared constants and types for the dancepad event transmitter.
// Button bit positions in pad_in, default timing, and the serializer state encoding.
package dancepad_event_tx_pkg;

    localparam int BUTTON_LEFT     = 0;
    localparam int BUTTON_DOWN     = 1;
    localparam int BUTTON_UP       = 2;
    localparam int BUTTON_RIGHT    = 3;
    localparam int BUTTON_UPLEFT   = 4;
    localparam int BUTTON_UPRIGHT  = 5;
    localparam int BUTTON_SELECT   = 6;
    localparam int BUTTON_START    = 7;

    localparam int BAUD_DIV_DEFAULT = 10417;
    localparam int DEBOUNCE_DEFAULT = 100000;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/dancepad_event_tx_if.sv
// Pad/UART bundle: raw pad levels in, serial line, busy flag and last-sent byte out.
// slave is the transmitter side, master is the pad/host side.
interface dancepad_event_tx_if;
    logic [7:0] pad_in;
    logic       TxD;
    logic       busy;
    logic [7:0] sent_byte;

    modport slave  (input pad_in, output TxD, output busy, output sent_byte);
    modport master (output pad_in, input TxD, input busy, input sent_byte);
endinterface

// File: rtl/dancepad_event_tx_uart_transmitter.sv
// 8N1 serializer: start pulse latches data, frame is 10*BAUD_DIV cycles, TxD registered.
// start is only honoured in IDLE; done pulses on the last stop-bit cycle.
module uart_transmitter
    import dancepad_event_tx_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       busy_o,
    output logic       txd_o,
    output logic       done_o,
    output logic [7:0] byte_o
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          bit_end;

    assign bit_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_o    = 1'b0;
        txd_d     = 1'b1;
        case (state_q)
            TX_IDLE: begin
                baud_d = '0;
                if (start_i) begin
                    state_d = TX_START;
                    shift_d = data_i;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = TX_DATA;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) state_d = TX_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            TX_STOP: begin
                if (bit_end) begin
                    baud_d  = '0;
                    done_o  = 1'b1;
                    state_d = TX_IDLE;
                end
            end
            default: state_d = TX_IDLE;
        endcase
        // Line level is computed from the next state so TxD leaves a flop aligned with the state.
        case (state_d)
            TX_START: txd_d = 1'b0;
            TX_DATA:  txd_d = shift_d[bit_idx_d];
            default:  txd_d = 1'b1;
        endcase
    end

    assign busy_o = (state_q != TX_IDLE);
    assign txd_o  = txd_q;
    assign byte_o = shift_q;

endmodule

// File: rtl/dancepad_event_tx.sv
// Dancepad state sender: synchronize, debounce, and transmit each new stable pad byte over UART.
// TxD falls 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after a clean pad change; frames never truncate.
module dancepad_event_tx
    import dancepad_event_tx_pkg::*;
#(
    parameter int BAUD_DIV        = BAUD_DIV_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    dancepad_event_tx_if.slave   bus
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [7:0]    sync1_q, sync_q;
    logic [7:0]    cand_q, cand_d;
    logic [7:0]    stable_q, stable_d;
    logic [7:0]    sent_q, sent_d;
    logic [DW-1:0] db_cnt_q, db_cnt_d;

    logic          tx_start, tx_busy, tx_txd, tx_done;
    logic [7:0]    tx_byte;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= '0;
            sync_q   <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            sent_q   <= '0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= bus.pad_in;
            sync_q   <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            sent_q   <= sent_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    always_comb begin
        cand_d   = cand_q;
        db_cnt_d = db_cnt_q;
        stable_d = stable_q;
        sent_d   = sent_q;
        if (sync_q != cand_q) begin
            cand_d   = sync_q;
            db_cnt_d = '0;
        end else begin
            if (db_cnt_q != DB_LAST) db_cnt_d = db_cnt_q + DW'(1);
            if (db_cnt_d == DB_LAST) stable_d = cand_q;
        end
        if (tx_done) sent_d = tx_byte;
    end

    // Only the latest stable value is ever offered, so changes during a frame coalesce.
    assign tx_start = (stable_q != sent_q) && !tx_busy;

    uart_transmitter #(
        .BAUD_DIV (BAUD_DIV)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .start_i (tx_start),
        .data_i  (stable_q),
        .busy_o  (tx_busy),
        .txd_o   (tx_txd),
        .done_o  (tx_done),
        .byte_o  (tx_byte)
    );

    assign bus.TxD       = tx_txd;
    assign bus.busy      = tx_busy;
    assign bus.sent_byte = sent_q;

endmodule

// File: tb/tb_dancepad_event_tx.sv
// Directed bench for dancepad_event_tx with BAUD_DIV=16, DEBOUNCE_CYCLES=4.
// Frames are decoded from TxD by a bench-side receiver and checked against hand-set bytes.
module tb_dancepad_event_tx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    dancepad_event_tx_if bus_if ();

    dancepad_event_tx #(
        .BAUD_DIV        (16),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input string tag, input int want);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus_if.TxD !== 1'b0 && n < 400);
        check(tag, n, want);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int bad;
        bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (bus_if.TxD !== 1'b1 || bus_if.busy !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Called on the negedge where the start bit is first visible; optional pad changes at frame cycles c1/c2.
    task automatic rx_frame(input string tag, input logic [7:0] exp,
                            input int c1, input logic [7:0] v1,
                            input int c2, input logic [7:0] v2);
        logic [15:0] samp;
        logic [7:0]  dec;
        logic        want;
        int          busy_cnt;
        int          i;
        busy_cnt = 0;
        dec = '0;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 16; k++) begin
                i = b * 16 + k;
                if (i > 0) @(negedge clk);
                if (i == c1) bus_if.pad_in = v1;
                if (i == c2) bus_if.pad_in = v2;
                samp[k] = bus_if.TxD;
                if (bus_if.busy === 1'b1) busy_cnt++;
            end
            if (b == 0)      want = 1'b0;
            else if (b == 9) want = 1'b1;
            else             want = exp[b-1];
            check($sformatf("%s bit%0d", tag, b), {16'h0, samp}, {16'h0, {16{want}}});
            if (b >= 1 && b <= 8) dec[b-1] = samp[8];
        end
        check({tag, " busy_len"}, busy_cnt, 160);
        @(negedge clk);
        check({tag, " busy_after"}, {31'h0, bus_if.busy}, 32'h0);
        check({tag, " sent_byte"}, {24'h0, bus_if.sent_byte}, {24'h0, exp});
        check({tag, " rx_byte"}, {24'h0, dec}, {24'h0, exp});
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] cur;
        bus_if.pad_in = 8'h00;

        // Reset values, both held and after release
        repeat (3) @(negedge clk);
        check("rst_txd", {31'h0, bus_if.TxD}, 32'h1);
        check("rst_busy", {31'h0, bus_if.busy}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rel_txd", {31'h0, bus_if.TxD}, 32'h1);
        check("rel_sent", {24'h0, bus_if.sent_byte}, 32'h0);

        // Bounce never holds long enough to be accepted
        for (int t = 0; t < 10; t++) begin
            bus_if.pad_in = (t % 2 == 0) ? 8'h04 : 8'h00;
            repeat (2) @(negedge clk);
        end
        bus_if.pad_in = 8'h00;
        quiet("bounce_quiet", 40);
        check("bounce_sent", {24'h0, bus_if.sent_byte}, 32'h0);

        // Single press: start bit after 2 + 4 + 1 cycles
        bus_if.pad_in = 8'h01;
        wait_start("press_latency", 7);
        rx_frame("press", 8'h01, -1, 8'h00, -1, 8'h00);
        quiet("press_quiet", 40);

        // Reset with pad held, then reset again during data bit 3
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_start("rst_first_latency", 7);
        repeat (70) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_txd", {31'h0, bus_if.TxD}, 32'h1);
        check("midrst_busy", {31'h0, bus_if.busy}, 32'h0);
        check("midrst_sent", {24'h0, bus_if.sent_byte}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_start("resend_latency", 7);
        rx_frame("resend", 8'h01, -1, 8'h00, -1, 8'h00);

        // Coalesce: 03 and 0B appear during the 01 frame, only 0B follows
        bus_if.pad_in = 8'h00;
        wait_start("coal_pre_latency", 7);
        rx_frame("coal_pre", 8'h00, -1, 8'h00, -1, 8'h00);
        bus_if.pad_in = 8'h01;
        wait_start("coal_a_latency", 7);
        rx_frame("coal_a", 8'h01, 20, 8'h03, 60, 8'h0B);
        wait_start("coal_gap", 1);
        rx_frame("coal_b", 8'h0B, -1, 8'h00, -1, 8'h00);
        quiet("coal_quiet", 60);

        // Revert: stable goes 01->00->01 while 01 is in flight from sent_byte=00
        bus_if.pad_in = 8'h00;
        wait_start("rev_pre_latency", 7);
        rx_frame("rev_pre", 8'h00, -1, 8'h00, -1, 8'h00);
        bus_if.pad_in = 8'h01;
        wait_start("rev_latency", 7);
        rx_frame("rev", 8'h01, 20, 8'h00, 60, 8'h01);
        quiet("rev_quiet", 60);

        // Loopback of a few random pad values
        cur = 8'h01;
        for (int r = 0; r < 4; r++) begin
            v = 8'($urandom_range(0, 255));
            if (v == cur) v = v ^ 8'h5A;
            cur = v;
            bus_if.pad_in = v;
            wait_start($sformatf("loop%0d_latency", r), 7);
            rx_frame($sformatf("loop%0d", r), v, -1, 8'h00, -1, 8'h00);
        end
        quiet("loop_quiet", 30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
